// File: rtl/ae_pkg.sv
// Shared types and sizing helpers for the autoencoder select-path sequencer.
// No logic; pure declarations.
package ae_pkg;

    localparam int SEL_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        STEP = 2'd1,
        DONE = 2'd2
    } seq_state_e;

    // Dwell counter width: enough to hold STEP_CYCLES-1, never narrower than one bit.
    function automatic int dwell_w(input int step_cycles);
        int w;
        w = $clog2(step_cycles);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/step_timer.sv
// Dwell counter for one select index; expired is combinational off the count register.
// Latency 0 (expired reflects current count); hold freezes the count, clr dominates hold.
module step_timer
    import ae_pkg::*;
#(
    parameter int STEP_CYCLES = 4,
    parameter int CNT_W       = dwell_w(STEP_CYCLES)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic hold,
    output logic expired
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STEP_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign expired = (cnt_q == LAST_CNT);

    // Saturates at LAST_CNT; the sequencer clears it when it moves to the next index.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (!hold && !expired) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/sel_seq.sv
// Select-index sequencer: walks sel_out 0..last_sel, dwelling STEP_CYCLES per index, en pulse per load.
// First index registered one edge after start; hold stalls dwell, delaying next index and done.
module sel_seq
    import ae_pkg::*;
#(
    parameter int SEL_W       = ae_pkg::SEL_W,
    parameter int STEP_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [SEL_W-1:0] last_sel,
    input  logic             hold,
    output logic [SEL_W-1:0] sel_out,
    output logic             en,
    output logic             busy,
    output logic             done
);

    seq_state_e       state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_W-1:0] last_q, last_d;
    logic             en_q, en_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             tmr_clr;
    logic             tmr_expired;

    step_timer #(
        .STEP_CYCLES (STEP_CYCLES)
    ) u_step_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (tmr_clr),
        .hold    (hold),
        .expired (tmr_expired)
    );

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        last_d  = last_q;
        en_d    = 1'b0;
        busy_d  = busy_q;
        done_d  = 1'b0;
        tmr_clr = 1'b1;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = STEP;
                    last_d  = last_sel;
                    sel_d   = '0;
                    en_d    = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            STEP: begin
                tmr_clr = 1'b0;
                // Compare before incrementing so last_sel = all-ones ends without wrapping.
                if (!hold && tmr_expired) begin
                    if (sel_q == last_q) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        sel_d   = sel_q + 1'b1;
                        en_d    = 1'b1;
                        tmr_clr = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= '0;
            last_q  <= '0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign sel_out = sel_q;
    assign en      = en_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_sel_seq.sv
// Bench for sel_seq: directed timing sweeps plus randomized traffic against a progress-count model.
// A second instance built with STEP_CYCLES=1 covers back-to-back en pulses.
module tb_sel_seq;

    localparam int S = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] last_sel;
    logic       hold;
    logic [3:0] sel_out;
    logic       en, busy, done;

    logic       start1;
    logic [3:0] last1;
    logic       hold1;
    logic [3:0] sel_out1;
    logic       en1, busy1, done1;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // Reference model: a sweep is a count of un-held cycles since start.
    bit m_active = 0;
    bit m_done_ph = 0;
    int m_prog = 0;
    int m_last = 0;
    int e_sel = 0;
    bit e_en = 0, e_busy = 0, e_done = 0;

    always #5 clk = ~clk;

    sel_seq #(.SEL_W(4), .STEP_CYCLES(S)) dut (
        .clk(clk), .rst(rst), .start(start), .last_sel(last_sel), .hold(hold),
        .sel_out(sel_out), .en(en), .busy(busy), .done(done)
    );

    sel_seq #(.SEL_W(4), .STEP_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .last_sel(last1), .hold(hold1),
        .sel_out(sel_out1), .en(en1), .busy(busy1), .done(done1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s @cyc %0d: got %0d expected %0d", tag, cyc, got, exp);
        end
    endtask

    task automatic model_step();
        if (rst) begin
            m_active = 0; m_done_ph = 0;
            e_sel = 0; e_en = 0; e_busy = 0; e_done = 0;
        end else if (m_done_ph) begin
            m_done_ph = 0;
            e_en = 0; e_busy = 0; e_done = 0;
        end else if (m_active) begin
            e_done = 0;
            e_en = 0;
            if (!hold) begin
                m_prog++;
                if (m_prog == (m_last + 1) * S) begin
                    m_active = 0; m_done_ph = 1; e_done = 1;
                end else begin
                    e_sel = m_prog / S;
                    e_en = (m_prog % S) == 0;
                end
            end
        end else begin
            e_en = 0; e_done = 0;
            if (start) begin
                m_active = 1; m_prog = 0; m_last = int'(last_sel);
                e_sel = 0; e_en = 1; e_busy = 1;
            end
        end
    endtask

    task automatic cycle(input logic s, input logic [3:0] ls, input logic h, input logic r);
        start = s; last_sel = ls; hold = h; rst = r;
        @(posedge clk);
        model_step();
        cyc++;
        @(negedge clk);
        chk("sel_out", 32'(sel_out), 32'(e_sel));
        chk("en", 32'(en), 32'(e_en));
        chk("busy", 32'(busy), 32'(e_busy));
        chk("done", 32'(done), 32'(e_done));
    endtask

    // Runs one sweep from IDLE; reports cycle offset of done and the number of en pulses.
    task automatic sweep(input logic [3:0] ls, input int hold_from, input int hold_len,
                         output int done_at, output int n_en);
        bit h;
        cycle(1'b1, ls, 1'b0, 1'b0);
        done_at = -1;
        n_en = en ? 1 : 0;
        for (int t = 1; t < 200; t++) begin
            h = (t >= hold_from) && (t < hold_from + hold_len);
            cycle(1'b0, 4'd0, h, 1'b0);
            if (en === 1'b1) n_en++;
            if (done === 1'b1 && done_at < 0) done_at = t;
            if (done_at >= 0 && t > done_at) break;
        end
    endtask

    initial begin
        int d, n;
        rst = 1'b1; start = 1'b0; last_sel = '0; hold = 1'b0;
        start1 = 1'b0; last1 = '0; hold1 = 1'b0;

        // Reset, with start asserted to show it is ignored.
        cycle(1'b1, 4'd5, 1'b0, 1'b1);
        cycle(1'b1, 4'd5, 1'b0, 1'b1);
        chk("rst_sel", 32'(sel_out), 0);
        chk("rst_busy", 32'(busy), 0);
        cycle(1'b0, 4'd0, 1'b0, 1'b0);

        sweep(4'd3, 1000, 0, d, n);
        chk("basic_done_at", d, 16);
        chk("basic_n_en", n, 4);
        chk("basic_sel_kept", 32'(sel_out), 3);
        chk("basic_busy_low", 32'(busy), 0);

        sweep(4'd3, 5, 3, d, n);
        chk("hold_done_at", d, 19);
        chk("hold_n_en", n, 4);

        sweep(4'd15, 1000, 0, d, n);
        chk("max_done_at", d, 64);
        chk("max_n_en", n, 16);
        chk("max_sel_kept", 32'(sel_out), 15);

        sweep(4'd0, 1000, 0, d, n);
        chk("one_done_at", d, 4);
        chk("one_n_en", n, 1);

        // Ignored restart, then reset mid-sweep.
        cycle(1'b1, 4'd3, 1'b0, 1'b0);
        for (int t = 1; t < 5; t++) cycle(1'b0, 4'd0, 1'b0, 1'b0);
        cycle(1'b1, 4'd9, 1'b0, 1'b0);
        chk("restart_sel", 32'(sel_out), 1);
        cycle(1'b0, 4'd0, 1'b0, 1'b1);
        chk("midrst_sel", 32'(sel_out), 0);
        chk("midrst_busy", 32'(busy), 0);
        n = 0;
        for (int t = 0; t < 20; t++) begin
            cycle(1'b0, 4'd0, 1'b0, 1'b0);
            if (done === 1'b1) n++;
        end
        chk("midrst_no_done", n, 0);
        sweep(4'd2, 1000, 0, d, n);
        chk("fresh_done_at", d, 12);

        // STEP_CYCLES=1 instance.
        start1 = 1'b1; last1 = 4'd2;
        cycle(1'b0, 4'd0, 1'b0, 1'b0);
        start1 = 1'b0; last1 = 4'd0;
        chk("s1_en0", 32'(en1), 1);
        chk("s1_sel0", 32'(sel_out1), 0);
        cycle(1'b0, 4'd0, 1'b0, 1'b0);
        chk("s1_en1", 32'(en1), 1);
        chk("s1_sel1", 32'(sel_out1), 1);
        cycle(1'b0, 4'd0, 1'b0, 1'b0);
        chk("s1_en2", 32'(en1), 1);
        chk("s1_sel2", 32'(sel_out1), 2);
        cycle(1'b0, 4'd0, 1'b0, 1'b0);
        chk("s1_en_off", 32'(en1), 0);
        chk("s1_done", 32'(done1), 1);
        cycle(1'b0, 4'd0, 1'b0, 1'b0);
        chk("s1_idle", 32'(busy1), 0);

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            logic s, h, r;
            logic [3:0] ls;
            s  = ($urandom_range(0, 7) == 0);
            h  = ($urandom_range(0, 3) == 0);
            r  = ($urandom_range(0, 299) == 0);
            ls = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
            cycle(s, ls, h, r);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sel_seq.md
# sel_seq

Upstream sequencer for the autoencoder's select memory: it generates the 4-bit select index and the one-cycle write-enable pulse that `sel_mem` registers. On a start pulse it walks the index from 0 up to a programmed last value, dwelling a fixed number of cycles on each index so the downstream weight/MAC datapath can settle. A downstream hold input stretches the dwell. A done pulse marks the end of the sweep.

## Interface
Parameters:
- `SEL_W`, 4, select index width; matches `sel_mem` `data_in`/`data_out`.
- `STEP_CYCLES`, 4, cycles spent on each index; legal range 1..255.

Ports:
- `clk`  input  1  system clock; every register updates on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `start`  input  1  single-cycle request to begin a sweep; honoured only in IDLE.
- `last_sel`  input  SEL_W  final index of the sweep; sampled on the accepted `start` cycle only.
- `hold`  input  1  downstream stall; freezes the dwell counter while high.
- `sel_out`  output  SEL_W  current index; drives `sel_mem.data_in`.
- `en`  output  1  one-cycle pulse when `sel_out` takes a new value; drives `sel_mem.en`.
- `busy`  output  1  high from sweep start through the done cycle.
- `done`  output  1  one-cycle pulse after the last index has finished its dwell.

## Operation
- All outputs are registered. Reset values: `sel_out`=0, `en`=0, `busy`=0, `done`=0, state=IDLE, dwell counter=0, latched last=0.
- States:
  - IDLE
    - `start`=1 → STEP.
    - In the same edge: latch `last_sel`, `sel_out`←0, `en`←1, `busy`←1, dwell←0.
  - STEP
    - `en` is 1 only in the first cycle after each index load; otherwise 0.
    - If `hold`=1: dwell holds its value.
    - Else if dwell≠STEP_CYCLES−1: dwell←dwell+1.
    - Else if `sel_out`==latched last: → DONE, `done`←1.
    - Else: `sel_out`←`sel_out`+1, `en`←1, dwell←0.
  - DONE
    - Lasts exactly one cycle with `done`=1 and `busy`=1.
    - Then → IDLE with `done`←0 and `busy`←0.
- `sel_out` keeps the last index after the sweep ends. It resets to 0 only on `rst` or the next accepted `start`.
- The equality test happens before any increment, so `last_sel`=2^SEL_W−1 never wraps.
- `last_sel`=0 gives a one-index sweep.
- `start` in STEP or DONE is ignored and is not queued.
- `hold` in IDLE or DONE is ignored.
- `hold` never stretches or repeats the `en` pulse. It delays only the next index and `done`.
- `rst` during STEP or DONE: return to IDLE with reset values on the next edge. No `done` pulse is issued.

## Timing
- Take `start` sampled at edge k with no hold.
- `en`/`sel_out`=i becomes visible after edge k+i·STEP_CYCLES, for i=0..last.
- `done`=1 in the cycle after edge k+(last+1)·STEP_CYCLES.
- Back in IDLE after one more edge.
- Each cycle of `hold`=1 in STEP adds one cycle to every subsequent event.
- With STEP_CYCLES=1, `en` stays high on consecutive cycles and the index advances every cycle.
- `sel_mem` captures `sel_out` on the edge where `en`=1. Its `data_out` therefore trails `sel_out` by one cycle.

## Structure
- Shared package `ae_pkg`:
  - `SEL_W` default.
  - State enum {IDLE, STEP, DONE}.
  - Width of the dwell counter, $clog2(STEP_CYCLES) clamped to ≥1.
- Natural sub-module `step_timer`:
  - Holds the dwell counter with `clr`, `hold` and `expired` (dwell==STEP_CYCLES−1) signals.
  - The FSM and index register stay in `sel_seq`.

## Test plan
- Reset check:
  - `rst` high for 2 cycles → all outputs 0.
  - `start` while `rst`=1 → ignored.
- Basic sweep, STEP_CYCLES=4, `last_sel`=3, `start` at edge k:
  - `en` pulses after edges k, k+4, k+8, k+12 with `sel_out`=0,1,2,3.
  - `done` after k+16; `busy` low after k+17.
  - `sel_out` stays 3.
- Hold: same sweep with `hold`=1 for 3 cycles during index 1 → `en` for index 2 at k+11, `done` at k+19, single `en` pulse per index.
- Boundary:
  - `last_sel`=15 → 16 pulses with indices 0..15, no wrap to 0, `done` at k+64.
  - `last_sel`=0 → one pulse, `done` at k+4.
- Ignored start and mid-sweep reset:
  - `start` re-asserted at k+5 → no effect on timing.
  - `rst` at k+6 → IDLE, `sel_out`=0, no `done`.
  - A fresh `start` then sweeps normally.
- STEP_CYCLES=1 build, `last_sel`=2 → `en` high 3 consecutive cycles with indices 0,1,2, then `done`. A connected `sel_mem` shows `data_out` 0,1,2 one cycle later.
